// File: rtl/bound_flasher_pkg.sv
// Shared types and defaults for the bound flasher LED sequencer.
package bound_flasher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_LED   = 16;
  localparam int unsigned DEF_NUM_PHASE = 6;
  // Phase 5 in the top slice down to phase 0 in the bottom slice.
  localparam logic [29:0] DEF_BOUND_INIT = {5'd0, 5'd5, 5'd0, 5'd10, 5'd5, 5'd15};
  localparam logic [16:0] DEF_KICK_MASK  = 17'h0_0021;

  function automatic int unsigned clip_bound(input int unsigned val, input int unsigned max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/bf_bound_table.sv
// Per-phase bound register file: reset-loaded defaults, checked and clipped
// write port, combinational read by phase index.
module bf_bound_table
  import bound_flasher_pkg::*;
#(
  parameter int unsigned               NUM_LED    = DEF_NUM_LED,
  parameter int unsigned               NUM_PHASE  = DEF_NUM_PHASE,
  parameter int unsigned               CNT_W      = 5,
  parameter int unsigned               PH_W       = 3,
  parameter logic [NUM_PHASE*CNT_W-1:0] BOUND_INIT = DEF_BOUND_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic             wr_allow,
  input  logic [PH_W-1:0]  wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [PH_W-1:0]  rd_addr,
  output logic [CNT_W-1:0] rd_bound,
  output logic             wr_reject
);

  logic [CNT_W-1:0] bound_q [NUM_PHASE];
  logic [CNT_W-1:0] bound_d [NUM_PHASE];
  logic             addr_ok;
  logic             wr_en;

  always_comb begin
    addr_ok   = ({1'b0, wr_addr} < (PH_W+1)'(NUM_PHASE));
    wr_en     = wr_req && wr_allow && addr_ok;
    wr_reject = wr_req && !wr_en;
    bound_d   = bound_q;
    if (wr_en) begin
      bound_d[wr_addr] = CNT_W'(clip_bound(32'(wr_data), NUM_LED));
    end
    rd_bound = bound_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PHASE; i++) begin
        bound_q[i] <= BOUND_INIT[i*CNT_W +: CNT_W];
      end
    end else begin
      bound_q <= bound_d;
    end
  end

endmodule

// File: rtl/bound_flasher_gen.sv
// Thermometer LED sequencer: a flick edge starts alternating UP/DOWN sweeps,
// each phase moving the lit-LED count towards its programmable bound.
module bound_flasher_gen
  import bound_flasher_pkg::*;
#(
  parameter int unsigned                               NUM_LED    = DEF_NUM_LED,
  parameter int unsigned                               NUM_PHASE  = DEF_NUM_PHASE,
  parameter logic [NUM_PHASE*$clog2(NUM_LED+1)-1:0]    BOUND_INIT = DEF_BOUND_INIT,
  parameter logic [NUM_LED:0]                          KICK_MASK  = DEF_KICK_MASK,
  parameter bit                                        REPEAT     = 1'b0,
  localparam int unsigned                              CNT_W      = $clog2(NUM_LED+1),
  localparam int unsigned                              PH_W       = $clog2(NUM_PHASE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flick,
  input  logic               step_en,
  input  logic               cfg_we,
  input  logic [PH_W-1:0]    cfg_addr,
  input  logic [CNT_W-1:0]   cfg_bound,
  output logic [NUM_LED-1:0] led,
  output logic [CNT_W-1:0]   level,
  output logic [PH_W-1:0]    phase,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(NUM_PHASE - 1);
  localparam logic [CNT_W-1:0] MAX_LVL = CNT_W'(NUM_LED);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               flick_q, flick_d;

  logic               start;
  logic               run_end;
  logic [CNT_W-1:0]   lvl_inc, lvl_dec;
  logic [CNT_W-1:0]   bound;
  logic               wr_reject;

  bf_bound_table #(
    .NUM_LED    (NUM_LED),
    .NUM_PHASE  (NUM_PHASE),
    .CNT_W      (CNT_W),
    .PH_W       (PH_W),
    .BOUND_INIT (BOUND_INIT)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (cfg_we),
    .wr_allow  ((state_q == IDLE) && !start),
    .wr_addr   (cfg_addr),
    .wr_data   (cfg_bound),
    .rd_addr   (phase_q),
    .rd_bound  (bound),
    .wr_reject (wr_reject)
  );

  always_comb begin
    start   = (state_q == IDLE) && flick && !flick_q;
    lvl_inc = (level_q == MAX_LVL) ? level_q : level_q + CNT_W'(1);
    lvl_dec = (level_q == '0) ? level_q : level_q - CNT_W'(1);

    state_d   = state_q;
    level_d   = level_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    run_end   = 1'b0;
    flick_d   = flick;
    cfg_err_d = wr_reject;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = UP;
          phase_d = '0;
          level_d = CNT_W'(1);
        end
      end
      UP: begin
        if (step_en) begin
          if (level_q < bound) begin
            level_d = lvl_inc;
          end else if (phase_q != LAST_PH) begin
            state_d = DOWN;
            phase_d = phase_q + PH_W'(1);
            level_d = lvl_dec;
          end else begin
            run_end = 1'b1;
          end
        end
      end
      DOWN: begin
        if (step_en) begin
          // Kickback outranks both the bound turn and the end of the run.
          if (KICK_MASK[level_q] && flick) begin
            state_d = UP;
            phase_d = phase_q - PH_W'(1);
            level_d = lvl_inc;
          end else if (level_q > bound) begin
            level_d = lvl_dec;
          end else if (phase_q != LAST_PH) begin
            state_d = UP;
            phase_d = phase_q + PH_W'(1);
            level_d = lvl_inc;
          end else begin
            run_end = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (run_end) begin
      done_d = 1'b1;
      if (REPEAT) begin
        state_d = UP;
        phase_d = '0;
        level_d = lvl_inc;
      end else begin
        state_d = IDLE;
        phase_d = '0;
        level_d = '0;
      end
    end

    busy_d = (state_d != IDLE);
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      led_d[i] = (32'(level_d) > i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= '0;
      phase_q   <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      flick_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      phase_q   <= phase_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      flick_q   <= flick_d;
    end
  end

  assign led     = led_q;
  assign level   = level_q;
  assign phase   = phase_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Scoreboard bench: the driver queues hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the selected instance.
module tb_bound_flasher_gen;

  logic        clk;
  logic        rst_n;
  logic        flick;
  logic        step_en;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [4:0]  cfg_bound;

  logic [15:0] led0, led1;
  logic [4:0]  level0, level1;
  logic [2:0]  phase0, phase1;
  logic        busy0, busy1, done0, done1, err0, err1;

  bound_flasher_gen u_dut (
    .clk(clk), .rst_n(rst_n), .flick(flick), .step_en(step_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bound(cfg_bound),
    .led(led0), .level(level0), .phase(phase0),
    .busy(busy0), .done(done0), .cfg_err(err0)
  );

  bound_flasher_gen #(.REPEAT(1'b1)) u_rep (
    .clk(clk), .rst_n(rst_n), .flick(flick), .step_en(step_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bound(cfg_bound),
    .led(led1), .level(level1), .phase(phase1),
    .busy(busy1), .done(done1), .cfg_err(err1)
  );

  typedef struct {
    int    sel;
    string tag;
    int    lvl;
    int    ph;
    logic  bz;
    logic  dn;
    logic  er;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  int    n_chk = 0;
  int    n_fail = 0;
  int    sel = 0;
  string tag = "reset";
  int    cur_level = 0;
  int    cur_phase = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input int s, input string t, input int lvl, input int ph,
                              input logic bz, input logic dn, input logic er);
    logic [15:0] a_led;
    logic [4:0]  a_lvl;
    logic [2:0]  a_ph;
    logic        a_bz, a_dn, a_er;
    logic [16:0] therm;
    if (s == 0) begin
      a_led = led0; a_lvl = level0; a_ph = phase0; a_bz = busy0; a_dn = done0; a_er = err0;
    end else begin
      a_led = led1; a_lvl = level1; a_ph = phase1; a_bz = busy1; a_dn = done1; a_er = err1;
    end
    therm = (17'd1 << lvl) - 17'd1;
    n_chk++;
    if ({a_led, a_lvl, a_ph, a_bz, a_dn, a_er} !==
        {therm[15:0], 5'(lvl), 3'(ph), bz, dn, er}) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got led=%h lvl=%0d ph=%0d busy=%b done=%b err=%b; required led=%h lvl=%0d ph=%0d busy=%b done=%b err=%b",
               t, s, $time, a_led, a_lvl, a_ph, a_bz, a_dn, a_er,
               therm[15:0], lvl, ph, bz, dn, er);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk(mon_e.sel, mon_e.tag, mon_e.lvl, mon_e.ph, mon_e.bz, mon_e.dn, mon_e.er);
    end
  end

  // One clock: drive inputs, then queue what the outputs must show after the edge.
  task automatic cyc(input logic f, input logic s, input logic we, input int a, input int b,
                     input int lvl, input int ph, input logic bz, input logic dn, input logic er);
    exp_t e;
    flick = f; step_en = s; cfg_we = we; cfg_addr = 3'(a); cfg_bound = 5'(b);
    @(posedge clk);
    e.sel = sel; e.tag = tag; e.lvl = lvl; e.ph = ph; e.bz = bz; e.dn = dn; e.er = er;
    q.push_back(e);
    cur_level = lvl;
    cur_phase = ph;
    #1;
  endtask

  task automatic seg(input int ph, input int from, input int to, input logic f, input int period);
    int d;
    d = (to >= from) ? 1 : -1;
    for (int v = from; ; v += d) begin
      for (int k = 1; k < period; k++) cyc(f, 1'b0, 1'b0, 0, 0, cur_level, cur_phase, 1'b1, 1'b0, 1'b0);
      cyc(f, 1'b1, 1'b0, 0, 0, v, ph, 1'b1, 1'b0, 1'b0);
      if (v == to) break;
    end
  endtask

  task automatic start_run();
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic end_idle();
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    flick = 1'b0; step_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_bound = '0;
    rst_n = 1'b0;
    #1;
    chk(0, "reset_async", 0, 0, 1'b0, 1'b0, 1'b0);
    chk(1, "reset_async", 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur_level = 0;
    cur_phase = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flick = 1'b0; step_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_bound = '0;
    do_reset();
    sel = 0;

    tag = "idle";
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    tag = "full_run";
    start_run();
    seg(0, 2, 15, 1'b0, 1); seg(1, 14, 5, 1'b0, 1); seg(2, 6, 10, 1'b0, 1);
    seg(3, 9, 0, 1'b0, 1);  seg(4, 1, 5, 1'b0, 1);  seg(5, 4, 0, 1'b0, 1);
    end_idle();

    tag = "kickback";
    start_run();
    seg(0, 2, 15, 1'b0, 1); seg(1, 14, 5, 1'b0, 1);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 6, 0, 1'b1, 1'b0, 1'b0);
    seg(0, 7, 15, 1'b0, 1); seg(1, 14, 5, 1'b0, 1); seg(2, 6, 10, 1'b0, 1);
    seg(3, 9, 0, 1'b0, 1);  seg(4, 1, 5, 1'b0, 1);  seg(5, 4, 0, 1'b0, 1);
    end_idle();

    tag = "end_kick";
    start_run();
    seg(0, 2, 15, 1'b0, 1); seg(1, 14, 5, 1'b0, 1); seg(2, 6, 10, 1'b0, 1);
    seg(3, 9, 0, 1'b0, 1);  seg(4, 1, 5, 1'b0, 1);  seg(5, 4, 3, 1'b0, 1);
    seg(5, 2, 0, 1'b1, 1);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 1, 4, 1'b1, 1'b0, 1'b0);
    seg(4, 2, 5, 1'b0, 1);  seg(5, 4, 0, 1'b0, 1);
    end_idle();

    tag = "cfg_write8";
    cyc(1'b0, 1'b0, 1'b1, 0, 8, 0, 0, 1'b0, 1'b0, 1'b0);
    tag = "cfg_start_clash";
    cyc(1'b1, 1'b1, 1'b1, 0, 2, 1, 0, 1'b1, 1'b0, 1'b1);
    tag = "peak8_run";
    seg(0, 2, 4, 1'b0, 1);
    tag = "cfg_busy";
    cyc(1'b0, 1'b1, 1'b1, 0, 3, 5, 0, 1'b1, 1'b0, 1'b1);
    tag = "peak8_run";
    seg(0, 6, 8, 1'b0, 1);  seg(1, 7, 5, 1'b0, 1);  seg(2, 6, 10, 1'b0, 1);
    seg(3, 9, 0, 1'b0, 1);  seg(4, 1, 5, 1'b0, 1);  seg(5, 4, 0, 1'b0, 1);
    end_idle();

    tag = "cfg_bad_addr";
    cyc(1'b0, 1'b0, 1'b1, 7, 3, 0, 0, 1'b0, 1'b0, 1'b1);
    tag = "cfg_clip";
    cyc(1'b0, 1'b0, 1'b1, 0, 31, 0, 0, 1'b0, 1'b0, 1'b0);
    tag = "peak16_run";
    start_run();
    seg(0, 2, 16, 1'b0, 1); seg(1, 15, 5, 1'b0, 1); seg(2, 6, 10, 1'b0, 1);
    seg(3, 9, 0, 1'b0, 1);  seg(4, 1, 5, 1'b0, 1);  seg(5, 4, 0, 1'b0, 1);
    end_idle();

    tag = "held_flick";
    cyc(1'b0, 1'b0, 1'b1, 5, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    start_run();
    seg(0, 2, 16, 1'b0, 1); seg(1, 15, 5, 1'b0, 1); seg(2, 6, 10, 1'b0, 1);
    seg(3, 9, 0, 1'b0, 1);  seg(4, 1, 1, 1'b0, 1);  seg(4, 2, 5, 1'b1, 1);
    seg(5, 4, 3, 1'b1, 1);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    tag = "slow_step";
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0);
    seg(0, 2, 15, 1'b0, 4); seg(1, 14, 5, 1'b0, 4); seg(2, 6, 8, 1'b0, 4);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 8, 2, 1'b1, 1'b0, 1'b0);
    tag = "reset_mid_run";
    do_reset();
    tag = "post_reset_run";
    start_run();
    seg(0, 2, 15, 1'b0, 1); seg(1, 14, 5, 1'b0, 1); seg(2, 6, 10, 1'b0, 1);
    seg(3, 9, 0, 1'b0, 1);  seg(4, 1, 5, 1'b0, 1);  seg(5, 4, 0, 1'b0, 1);
    end_idle();

    tag = "repeat_run";
    do_reset();
    sel = 1;
    start_run();
    seg(0, 2, 15, 1'b0, 1); seg(1, 14, 5, 1'b0, 1); seg(2, 6, 10, 1'b0, 1);
    seg(3, 9, 0, 1'b0, 1);  seg(4, 1, 5, 1'b0, 1);  seg(5, 4, 0, 1'b0, 1);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0);
    seg(0, 2, 15, 1'b0, 1); seg(1, 14, 10, 1'b0, 1);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
